// File: rtl/shim_spi_cfg_apply_ctrl.sv
`timescale 1ns/1ps
// Applies synchronized SPI/integrator configuration atomically once inputs are stable
// and the datapath is quiescent; also provides a fast disable path for the enables.
module shim_spi_cfg_apply_ctrl #(
  parameter int unsigned STABLE_HOLD     = 4,
  parameter int unsigned QUIESCE_TIMEOUT = 1024,
  parameter logic [31:0] MIN_WINDOW      = 32'd2048
) (
  input  logic        spi_clk,
  input  logic        sync_resetn,
  input  logic [14:0] integ_thresh_avg_sync,
  input  logic [31:0] integ_window_sync,
  input  logic        integ_en_sync,
  input  logic        spi_en_sync,
  input  logic        all_stable,
  input  logic        core_idle,
  input  logic        apply_req,
  output logic [14:0] integ_thresh_avg_act,
  output logic [31:0] integ_window_act,
  output logic        integ_en_act,
  output logic        spi_en_act,
  output logic        busy,
  output logic        apply_done,
  output logic        cfg_err,
  output logic [1:0]  err_code
);

  localparam int unsigned SCW = (STABLE_HOLD > 1) ? $clog2(STABLE_HOLD) : 1;
  localparam int unsigned TCW = (QUIESCE_TIMEOUT > 1) ? $clog2(QUIESCE_TIMEOUT) : 1;
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_HOLD - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(QUIESCE_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_WINDOW  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_QUIESCE,
    S_APPLY,
    S_ERROR
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [SCW-1:0] stable_cnt;
  logic [SCW-1:0] stable_cnt_d;
  logic [TCW-1:0] to_cnt;
  logic [TCW-1:0] to_cnt_d;
  logic           pending;
  logic           pending_d;
  logic           load_q;

  logic           window_low_c;
  logic           accept_c;
  logic           load_c;
  logic           err_win_c;
  logic           err_to_c;

  assign window_low_c = (integ_window_sync < MIN_WINDOW);

  // State register
  always_ff @(posedge spi_clk) begin
    if (!sync_resetn) state <= S_IDLE;
    else              state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (apply_req || pending) next_state = S_SETTLE;
      S_SETTLE:  if (all_stable && (stable_cnt == STABLE_LAST)) next_state = S_QUIESCE;
      S_QUIESCE: begin
        if (core_idle)                    next_state = S_APPLY;
        else if (to_cnt == TIMEOUT_LAST)  next_state = S_ERROR;
      end
      S_APPLY:   next_state = window_low_c ? S_ERROR : S_IDLE;
      S_ERROR:   next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Control strobes and counter/pending next values
  always_comb begin
    accept_c     = 1'b0;
    load_c       = 1'b0;
    err_win_c    = 1'b0;
    err_to_c     = 1'b0;
    stable_cnt_d = stable_cnt;
    to_cnt_d     = to_cnt;
    pending_d    = pending;
    case (state)
      S_IDLE: begin
        // Pending is either consumed here or was already clear
        pending_d = 1'b0;
        if (apply_req || pending) begin
          accept_c     = 1'b1;
          stable_cnt_d = '0;
        end
      end
      S_SETTLE: begin
        to_cnt_d = '0;
        if (all_stable && (stable_cnt != STABLE_LAST)) stable_cnt_d = stable_cnt + SCW'(1);
        else                                          stable_cnt_d = '0;
      end
      S_QUIESCE: begin
        if (!core_idle) begin
          if (to_cnt == TIMEOUT_LAST) begin
            err_to_c = 1'b1;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt + TCW'(1);
          end
        end
      end
      S_APPLY: begin
        load_c    = !window_low_c;
        err_win_c = window_low_c;
      end
      default: ;
    endcase
    if ((state != S_IDLE) && apply_req) pending_d = 1'b1;
  end

  // Registered outputs, counters and active configuration
  always_ff @(posedge spi_clk) begin
    if (!sync_resetn) begin
      stable_cnt           <= '0;
      to_cnt               <= '0;
      pending              <= 1'b0;
      load_q               <= 1'b0;
      busy                 <= 1'b0;
      apply_done           <= 1'b0;
      cfg_err              <= 1'b0;
      err_code             <= ERR_NONE;
      integ_thresh_avg_act <= '0;
      integ_window_act     <= '0;
      integ_en_act         <= 1'b0;
      spi_en_act           <= 1'b0;
    end else begin
      stable_cnt <= stable_cnt_d;
      to_cnt     <= to_cnt_d;
      pending    <= pending_d;
      busy       <= (next_state != S_IDLE);
      load_q     <= load_c;
      apply_done <= load_q;

      if (accept_c) begin
        cfg_err  <= 1'b0;
        err_code <= ERR_NONE;
      end else if (err_win_c) begin
        cfg_err  <= 1'b1;
        err_code <= ERR_WINDOW;
      end else if (err_to_c) begin
        cfg_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end

      if (load_c) begin
        integ_thresh_avg_act <= integ_thresh_avg_sync;
        integ_window_act     <= integ_window_sync;
      end

      // Fast disable beats a same-cycle load for the enable bits only
      if (!spi_en_sync) begin
        spi_en_act   <= 1'b0;
        integ_en_act <= 1'b0;
      end else if (load_c) begin
        spi_en_act   <= spi_en_sync;
        integ_en_act <= integ_en_sync;
      end
    end
  end

endmodule

// File: tb/tb_shim_spi_cfg_apply_ctrl.sv
`timescale 1ns/1ps
// Scenario bench for shim_spi_cfg_apply_ctrl: expected active configs are queued at
// request time and checked against the outputs whenever apply_done pulses.
module tb_shim_spi_cfg_apply_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [14:0] thresh;
  logic [31:0] window;
  logic        integ_en, spi_en, all_stable, core_idle, apply_req;
  logic [14:0] thresh_act;
  logic [31:0] window_act;
  logic        integ_en_act, spi_en_act, busy, apply_done, cfg_err;
  logic [1:0]  err_code;

  typedef struct packed {
    logic [14:0] t;
    logic [31:0] w;
    logic        ie;
    logic        se;
  } cfg_t;

  cfg_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  shim_spi_cfg_apply_ctrl dut (
    .spi_clk               (clk),
    .sync_resetn           (rstn),
    .integ_thresh_avg_sync (thresh),
    .integ_window_sync     (window),
    .integ_en_sync         (integ_en),
    .spi_en_sync           (spi_en),
    .all_stable            (all_stable),
    .core_idle             (core_idle),
    .apply_req             (apply_req),
    .integ_thresh_avg_act  (thresh_act),
    .integ_window_act      (window_act),
    .integ_en_act          (integ_en_act),
    .spi_en_act            (spi_en_act),
    .busy                  (busy),
    .apply_done            (apply_done),
    .cfg_err               (cfg_err),
    .err_code              (err_code)
  );

  // Expected active config for the current inputs; the enable bits never survive spi_en=0
  function automatic cfg_t cur_exp();
    cfg_t c;
    c.t  = thresh;
    c.w  = window;
    c.ie = integ_en & spi_en;
    c.se = spi_en;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every apply_done must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    cfg_t e;
    cfg_t got;
    if (apply_done === 1'b1) begin
      done_pulses++;
      vectors++;
      got = {thresh_act, window_act, integ_en_act, spi_en_act};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL apply_done_unexpected: got act=%h with no queued expectation", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL apply_values: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0; apply_req = 1'b0;
    thresh = 15'h1234; window = 32'd4096; integ_en = 1'b1; spi_en = 1'b1;
    all_stable = 1'b1; core_idle = 1'b1;
    tick(); tick();
    vectors++;
    if ({thresh_act, window_act, integ_en_act, spi_en_act, busy, apply_done, cfg_err, err_code} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got act=%h/%h en=%b%b busy=%b done=%b err=%b code=%0d, required all 0",
               thresh_act, window_act, integ_en_act, spi_en_act, busy, apply_done, cfg_err, err_code);
    end
    rstn = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b, required 0", busy); end
  endtask

  task automatic test_latency();
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL latency_busy: got %b, required 1", busy); end
    repeat (5) tick();
    vectors++;
    if (window_act !== 32'd0) begin miscompares++; $display("FAIL latency_early: window_act=%0d, required 0", window_act); end
    tick();
    vectors++;
    if ({thresh_act, window_act, integ_en_act, spi_en_act} !== {15'h1234, 32'd4096, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL latency_update: got %h/%0d/%b%b, required 1234/4096/11", thresh_act, window_act, integ_en_act, spi_en_act);
    end
    vectors++;
    if (apply_done !== 1'b0) begin miscompares++; $display("FAIL latency_done_early: got %b, required 0", apply_done); end
    tick();
    vectors++;
    if (apply_done !== 1'b1) begin miscompares++; $display("FAIL latency_done: got %b, required 1", apply_done); end
    tick();
    vectors++;
    if (apply_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL latency_done_single: done=%b busy=%b, required 0 0", apply_done, busy);
    end
  endtask

  task automatic test_settle_glitch();
    window = 32'd6000; thresh = 15'h0abc;
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    repeat (3) tick();
    all_stable = 1'b0; tick(); all_stable = 1'b1;
    repeat (5) tick();
    vectors++;
    if (window_act !== 32'd4096) begin miscompares++; $display("FAIL glitch_early: window_act=%0d, required 4096", window_act); end
    tick();
    vectors++;
    if (window_act !== 32'd6000) begin miscompares++; $display("FAIL glitch_apply: window_act=%0d, required 6000", window_act); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    int target;
    window = 32'd8192; thresh = 15'h0555; core_idle = 1'b0;
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    n = 0;
    while (cfg_err !== 1'b1 && n < 2000) begin tick(); n++; end
    vectors++;
    if (n != 1028) begin miscompares++; $display("FAIL timeout_cycles: got %0d, required 1028", n); end
    vectors++;
    if (err_code !== 2'd2 || window_act !== 32'd6000 || busy !== 1'b1) begin
      miscompares++; $display("FAIL timeout_state: code=%0d window_act=%0d busy=%b, required 2 6000 1", err_code, window_act, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || cfg_err !== 1'b1 || err_code !== 2'd2) begin
      miscompares++; $display("FAIL timeout_hold: busy=%b err=%b code=%0d, required 0 1 2", busy, cfg_err, err_code);
    end
    core_idle = 1'b1;
    target = done_pulses + 1;
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0 || err_code !== 2'd0) begin
      miscompares++; $display("FAIL timeout_clear: err=%b code=%0d, required 0 0", cfg_err, err_code);
    end
    n = 0;
    while (done_pulses < target && n < 20) begin tick(); n++; end
    vectors++;
    if (done_pulses != target) begin miscompares++; $display("FAIL timeout_recover: done=%0d, required %0d", done_pulses, target); end
    tick();
  endtask

  task automatic test_window_err();
    int n;
    int target;
    window = 32'd100; thresh = 15'h7fff;
    target = done_pulses + 1;
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    repeat (6) tick();
    vectors++;
    if (cfg_err !== 1'b1 || err_code !== 2'd1) begin
      miscompares++; $display("FAIL window_err: err=%b code=%0d, required 1 1", cfg_err, err_code);
    end
    vectors++;
    if (window_act !== 32'd8192 || thresh_act !== 15'h0555) begin
      miscompares++; $display("FAIL window_keep: act=%h/%0d, required 0555/8192", thresh_act, window_act);
    end
    // Request arrives in the same cycle the FSM leaves ERROR
    window = 32'd4096; thresh = 15'h0321;
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL err_exit_hold: err=%b busy=%b, required 1 0", cfg_err, busy);
    end
    tick();
    vectors++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL err_exit_pending: err=%b busy=%b, required 0 1", cfg_err, busy);
    end
    n = 0;
    while (done_pulses < target && n < 20) begin tick(); n++; end
    repeat (3) tick();
    vectors++;
    if (done_pulses != target) begin miscompares++; $display("FAIL err_exit_done: done=%0d, required %0d", done_pulses, target); end
  endtask

  task automatic test_back_to_back();
    int n;
    int target;
    window = 32'd12345; thresh = 15'h2222; core_idle = 1'b0;
    target = done_pulses + 2;
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    repeat (6) tick();
    exp_q.push_back(cur_exp());
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    tick();
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    core_idle = 1'b1;
    n = 0;
    while (done_pulses < target && n < 40) begin tick(); n++; end
    repeat (20) tick();
    vectors++;
    if (done_pulses != target) begin miscompares++; $display("FAIL b2b_done_count: got %0d, required %0d", done_pulses, target); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_fast_disable();
    int n;
    int target;
    window = 32'd20000; thresh = 15'h1111;
    target = done_pulses + 1;
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    tick(); tick();
    spi_en = 1'b0;
    exp_q.push_back(cur_exp());
    tick();
    vectors++;
    if (spi_en_act !== 1'b0 || integ_en_act !== 1'b0 || window_act !== 32'd12345 || busy !== 1'b1) begin
      miscompares++; $display("FAIL fast_disable: en=%b%b window_act=%0d busy=%b, required 00 12345 1",
                              integ_en_act, spi_en_act, window_act, busy);
    end
    n = 0;
    while (done_pulses < target && n < 20) begin tick(); n++; end
    vectors++;
    if (done_pulses != target) begin miscompares++; $display("FAIL fast_disable_done: done=%0d, required %0d", done_pulses, target); end
    spi_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int base;
    window = 32'd30000; core_idle = 1'b0;
    apply_req = 1'b1; tick(); apply_req = 1'b0;
    repeat (6) tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_mid_busy: got %b, required 1", busy); end
    base = done_pulses;
    rstn = 1'b0; tick();
    vectors++;
    if ({thresh_act, window_act, integ_en_act, spi_en_act, busy, apply_done, cfg_err, err_code} !== '0) begin
      miscompares++; $display("FAIL reset_mid_outputs: act=%h/%0d en=%b%b busy=%b err=%b, required all 0",
                              thresh_act, window_act, integ_en_act, spi_en_act, busy, cfg_err);
    end
    rstn = 1'b1; core_idle = 1'b1;
    repeat (10) tick();
    vectors++;
    if (done_pulses != base || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_abort: done=%0d busy=%b, required %0d 0", done_pulses, busy, base);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_settle_glitch();
    test_timeout();
    test_window_err();
    test_back_to_back();
    test_fast_disable();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shim_spi_cfg_apply_ctrl.md
SHIM_SPI_CFG_APPLY_CTRL -- requirements
Module: shim_spi_cfg_apply_ctrl

Interface
REQ-001 SHALL have parameter STABLE_HOLD, default 4: consecutive cycles all_stable must be high before an apply.
REQ-002 SHALL have parameter QUIESCE_TIMEOUT, default 1024: maximum cycles to wait for core_idle.
REQ-003 SHALL have parameter MIN_WINDOW, default 32'd2048: smallest legal integ_window_sync value.
REQ-004 SHALL have port spi_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sync_resetn, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port integ_thresh_avg_sync, input, 15: synchronized threshold candidate.
REQ-007 SHALL have port integ_window_sync, input, 32: synchronized window candidate.
REQ-008 SHALL have port integ_en_sync, input, 1: synchronized integrator-enable candidate.
REQ-009 SHALL have port spi_en_sync, input, 1: synchronized SPI enable.
REQ-010 SHALL have port all_stable, input, 1: AND of all synchronizer stable flags.
REQ-011 SHALL have port core_idle, input, 1: high when the SPI datapath is between transactions.
REQ-012 SHALL have port apply_req, input, 1: request to apply the candidate configuration (level or pulse).
REQ-013 SHALL have port integ_thresh_avg_act, output, 15: active threshold.
REQ-014 SHALL have port integ_window_act, output, 32: active window.
REQ-015 SHALL have port integ_en_act, output, 1: active integrator enable.
REQ-016 SHALL have port spi_en_act, output, 1: active SPI enable.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port apply_done, output, 1: one-cycle pulse on a successful apply.
REQ-019 SHALL have port cfg_err, output, 1: sticky error flag.
REQ-020 SHALL have port err_code, output, 2: error cause: 0 none, 1 window below MIN_WINDOW, 2 quiesce timeout.

Function
REQ-021 SHALL implement the FSM states IDLE, SETTLE, QUIESCE, APPLY and ERROR.
REQ-022 IDLE: when apply_req or pending is high, the FSM SHALL go to SETTLE, clear pending, clear the stable counter, and clear cfg_err and err_code.
REQ-023 SETTLE: the stable counter SHALL increment each cycle all_stable=1 and reset to 0 each cycle all_stable=0.
REQ-024 SETTLE: when the counter reaches STABLE_HOLD-1 with all_stable=1, the FSM SHALL go to QUIESCE and clear the timeout counter; minimum SETTLE residency is STABLE_HOLD cycles.
REQ-025 QUIESCE: if core_idle=1, the FSM SHALL go to APPLY on the next edge.
REQ-026 QUIESCE: otherwise the timeout counter SHALL increment.
REQ-027 QUIESCE: when the timeout counter reaches QUIESCE_TIMEOUT-1 with core_idle=0, the FSM SHALL go to ERROR with err_code=2.
REQ-028 APPLY (one cycle): if integ_window_sync < MIN_WINDOW (unsigned compare), the FSM SHALL go to ERROR with err_code=1 and leave the active outputs unchanged.
REQ-029 APPLY: otherwise all four *_act outputs SHALL load their *_sync inputs on the same edge, apply_done SHALL pulse the following cycle, and the FSM SHALL return to IDLE.
REQ-030 ERROR: cfg_err SHALL be 1; the FSM SHALL return to IDLE after one cycle; cfg_err and err_code SHALL hold until the next accepted request.
REQ-031 apply_req seen while busy=1 SHALL set pending (single-deep); further requests while pending=1 SHALL be absorbed; pending SHALL be serviced on return to IDLE.
REQ-032 Fast disable: any cycle with spi_en_sync=0 SHALL clear spi_en_act and integ_en_act on the next edge in every state; an in-progress FSM SHALL continue; thresh and window values SHALL be untouched.
REQ-033 Fast disable SHALL take priority over a same-cycle APPLY load for the two enable bits only.
REQ-034 Simultaneous apply_req and ERROR exit SHALL set pending, and the request SHALL be serviced.
REQ-035 Latency from apply_req in IDLE with all_stable and core_idle constantly high to *_act update SHALL be STABLE_HOLD+2 edges; apply_done SHALL follow one edge later.

Reset
REQ-036 While sync_resetn=0 on an edge: FSM=IDLE, all counters 0, pending 0, all *_act 0, busy 0, apply_done 0, cfg_err 0, err_code 0.
REQ-037 Reset asserted mid-sequence SHALL abort without updating *_act beyond clearing them to 0.

Verification
REQ-038 Defaults; all_stable=1, core_idle=1, window=4096, thresh=0x1234, spi_en=1, integ_en=1; 1-cycle apply_req -> *_act update 6 edges later, apply_done pulses once.
REQ-039 all_stable drops for 1 cycle after 3 stable cycles in SETTLE -> counter restarts; apply occurs 4 stable cycles after recovery.
REQ-040 core_idle=0 held -> after 1024 QUIESCE cycles, cfg_err=1, err_code=2, *_act unchanged; next apply_req with core_idle=1 clears the error and applies.
REQ-041 window=100 -> cfg_err=1, err_code=1, no apply_done, *_act keep previous values.
REQ-042 Two apply_req pulses during QUIESCE -> exactly two apply_done pulses total; spi_en_sync=0 mid-SETTLE -> spi_en_act and integ_en_act 0 next edge.
REQ-043 sync_resetn low during QUIESCE -> all outputs 0, FSM IDLE, no apply_done.
